lb_fifo_core: RTL and testbench
===============================

# lb_fifo_core

Golden-model memory core for the A-QED harness: a synchronous FIFO-mode line buffer that consumes the harness's input stream (wen_in/data_in) and produces the output stream (valid_out/data_out) together with the empty/full status the harness monitors. It is the device side of the same interface the A-QED wrapper drives and observes. It serves as a known-good DUT for bring-up, and as the baseline that injected-bug variants are derived from.

## Interface
- DEPTH, 128, number of 16-bit entries; power of two, ≥ 2
- WIDTH, 16, data width
- CW, $clog2(DEPTH)+1, width of occupancy count
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high; clock clk
- clk_en  in  1  global enable; low freezes all state
- flush  in  1  synchronous clear of contents
- wen_in  in  1  write request
- data_in  in  WIDTH  write data
- ren_in  in  1  read request
- data_out  out  WIDTH  read data, registered
- valid_out  out  1  data_out holds a popped word
- empty  out  1  occupancy == 0
- full  out  1  occupancy == DEPTH
- count  out  CW  current occupancy
- ovf_err  out  1  sticky: write attempted while full
- udf_err  out  1  sticky: read attempted while empty

## Operation
- Storage: DEPTH×WIDTH array. Write pointer wp and read pointer rp are $clog2(DEPTH) bits and wrap DEPTH-1 → 0. Occupancy register cnt is CW bits.
- push = clk_en & ~flush & wen_in & ~full. Writes mem[wp] <= data_in and advances wp.
- pop = clk_en & ~flush & ren_in & ~empty. Sets data_out <= mem[rp] and advances rp.
- full and empty are decoded from the registered cnt. They are never derived from same-cycle requests.
- Push and pop in the same cycle are allowed: cnt is unchanged and both pointers advance.
- At full, a push is rejected even if a pop is accepted in the same cycle. That cycle therefore reduces cnt by 1.
- At empty, a pop is rejected even if a push is accepted in the same cycle. There is no write-to-read bypass.
- cnt update: +1 on push only, −1 on pop only, otherwise held.
- ovf_err sets on clk_en & ~flush & wen_in & full. udf_err sets on clk_en & ~flush & ren_in & empty. Both clear only on reset; flush does not clear them.
- Status states (decoded, not a separate FSM register):
  - EMPTY (cnt=0)
  - PARTIAL (0<cnt<DEPTH)
  - FULL (cnt=DEPTH)
  - Transitions occur only via the push/pop rules above.
- flush & clk_en: wp, rp and cnt go to 0, valid_out goes to 0, and any wen_in/ren_in that cycle is ignored. Array contents are don't-care. flush with clk_en low has no effect.
- Reset: wp, rp and cnt = 0, data_out = 0, valid_out = 0, ovf_err = udf_err = 0. Reset overrides clk_en and flush. Reset asserted mid-stream discards all contents on the next edge.

## Timing
- Read latency is 1 cycle. Pop accepted at edge N gives data_out/valid_out valid after edge N and visible during cycle N+1.
- valid_out = 1 for exactly one enabled cycle per accepted pop. On an enabled cycle with no pop, valid_out <= 0. data_out holds its last value when valid_out is 0.
- clk_en low: every register holds, including valid_out and data_out. Consumers qualify valid_out with clk_en.
- Write-to-read latency: a word pushed at edge N can be popped at edge N+1 at the earliest. It appears on data_out after edge N+1.
- empty, full and count change on the edge after the causing push/pop.
- Back-to-back pops on consecutive enabled cycles stream one word per cycle, with valid_out held high continuously.

## Test plan
- Reset, then push 0x0001..0x0005 on 5 cycles, then ren_in for 5 cycles → data_out 0x0001..0x0005 in order, each one cycle after its pop. count 5→0, empty returns to 1, valid_out low afterwards.
- Fill to DEPTH=128 (data = index), then wen_in with 0xBEEF and ren_in together → pop accepted (data_out=0x0000), push rejected, count=127, ovf_err=1. Drain remaining → 0x0001..0x007F, 0xBEEF never appears.
- Pointer wrap: push/pop alternating 300 words, data 0x1000+i → output matches input exactly, count ≤ 1 throughout, no error flags.
- Empty with wen_in=ren_in=1 (data 0x00AA) → udf_err=1, valid_out=0 next cycle, count=1. Next ren_in → data_out=0x00AA.
- Push 3 words, then flush with wen_in=1 → count=0, empty=1, valid_out=0, ovf_err/udf_err unchanged. Subsequent push 0x0042 then pop → data_out=0x0042.
- Push 0x0011, pop with clk_en toggling 1,0,0,1 → valid_out stays high through the clk_en-low cycles and drops on the next enabled cycle. Reset asserted mid-fill (count=10) → count=0, empty=1 next edge.

Source files
------------

// File: rtl/lb_fifo_core.sv
// rtl/lb_fifo_core.sv - synchronous FIFO-mode line buffer serving as the A-QED golden memory core
module lb_fifo_core #(
  parameter int DEPTH = 128,
  parameter int WIDTH = 16,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_en,
  input  logic             flush,
  input  logic             wen_in,
  input  logic [WIDTH-1:0] data_in,
  input  logic             ren_in,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count,
  output logic             ovf_err,
  output logic             udf_err
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic [CW-1:0]    cnt;
  logic             live;
  logic             push;
  logic             pop;

  // Status comes only from the registered occupancy, never from this cycle's requests.
  assign empty = (cnt == '0);
  assign full  = (cnt == CW'(DEPTH));
  assign count = cnt;

  assign live = clk_en & ~flush;
  assign push = live & wen_in & ~full;
  assign pop  = live & ren_in & ~empty;

  always_ff @(posedge clk) begin
    if (!reset && push) mem[wp] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wp        <= '0;
      rp        <= '0;
      cnt       <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      ovf_err   <= 1'b0;
      udf_err   <= 1'b0;
    end else if (clk_en) begin
      if (flush) begin
        wp        <= '0;
        rp        <= '0;
        cnt       <= '0;
        valid_out <= 1'b0;
      end else begin
        if (push) wp <= wp + 1'b1;
        if (pop) begin
          rp       <= rp + 1'b1;
          data_out <= mem[rp];
        end
        valid_out <= pop;
        if (push && !pop)      cnt <= cnt + 1'b1;
        else if (pop && !push) cnt <= cnt - 1'b1;
        // Error flags are sticky until reset; flush leaves them alone.
        if (wen_in && full)  ovf_err <= 1'b1;
        if (ren_in && empty) udf_err <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_lb_fifo_core.sv
// tb/tb_lb_fifo_core.sv - directed bench for lb_fifo_core with a queue-based reference model
module tb_lb_fifo_core;
  localparam int DEPTH = 128;
  localparam int WIDTH = 16;
  localparam int CW    = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             clk_en = 1'b0;
  logic             flush = 1'b0;
  logic             wen_in = 1'b0;
  logic             ren_in = 1'b0;
  logic [WIDTH-1:0] data_in = '0;
  logic [WIDTH-1:0] data_out;
  logic             valid_out;
  logic             empty;
  logic             full;
  logic [CW-1:0]    count;
  logic             ovf_err;
  logic             udf_err;

  lb_fifo_core #(.DEPTH(DEPTH), .WIDTH(WIDTH), .CW(CW)) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .flush(flush),
    .wen_in(wen_in), .data_in(data_in), .ren_in(ren_in),
    .data_out(data_out), .valid_out(valid_out), .empty(empty), .full(full),
    .count(count), .ovf_err(ovf_err), .udf_err(udf_err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit armed = 1'b0;

  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] seen[$];
  logic [WIDTH-1:0] m_data = '0;
  bit m_valid = 1'b0, m_ovf = 1'b0, m_udf = 1'b0;
  bit was_full, was_empty;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: the buffer is a plain queue, bounded at DEPTH.
  always @(posedge clk) begin
    armed = 1'b1;
    if (reset) begin
      q.delete();
      m_valid = 1'b0; m_data = '0; m_ovf = 1'b0; m_udf = 1'b0;
    end else if (clk_en) begin
      if (flush) begin
        q.delete();
        m_valid = 1'b0;
      end else begin
        was_full  = (q.size() == DEPTH);
        was_empty = (q.size() == 0);
        if (wen_in && was_full)  m_ovf = 1'b1;
        if (ren_in && was_empty) m_udf = 1'b1;
        m_valid = 1'b0;
        if (ren_in && !was_empty) begin
          m_data  = q.pop_front();
          m_valid = 1'b1;
        end
        if (wen_in && !was_full) q.push_back(data_in);
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      check("count", count, q.size());
      check("empty", empty, q.size() == 0);
      check("full", full, q.size() == DEPTH);
      check("valid_out", valid_out, m_valid);
      check("data_out", data_out, m_data);
      check("ovf_err", ovf_err, m_ovf);
      check("udf_err", udf_err, m_udf);
      if (valid_out && clk_en) seen.push_back(data_out);
    end
  end

  task automatic cyc(input bit en, input bit fl, input bit w, input bit r, input logic [WIDTH-1:0] d);
    clk_en = en; flush = fl; wen_in = w; ren_in = r; data_in = d;
    @(posedge clk); #1;
    clk_en = 1'b1; flush = 1'b0; wen_in = 1'b0; ren_in = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(1, 0, 0, 0, '0);
    reset = 1'b0;
  endtask

  initial begin
    do_reset();
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_valid", valid_out, 0);
    check("rst_data", data_out, 0);

    // In-order streaming of five words
    for (int i = 1; i <= 5; i++) cyc(1, 0, 1, 0, WIDTH'(i));
    check("t1_count", count, 5);
    seen.delete();
    for (int i = 1; i <= 5; i++) begin
      cyc(1, 0, 0, 1, '0);
      check("t1_data", data_out, i);
      check("t1_valid", valid_out, 1);
    end
    cyc(1, 0, 0, 0, '0);
    check("t1_empty", empty, 1);
    check("t1_valid_low", valid_out, 0);
    check("t1_seen_n", seen.size(), 5);
    for (int i = 0; i < 5 && i < seen.size(); i++) check("t1_seen", seen[i], i + 1);

    // Fill to DEPTH, then write+read at full
    do_reset();
    for (int i = 0; i < DEPTH; i++) cyc(1, 0, 1, 0, WIDTH'(i));
    check("t2_count_full", count, 128);
    check("t2_full", full, 1);
    seen.delete();
    cyc(1, 0, 1, 1, 16'hBEEF);
    check("t2_data0", data_out, 0);
    check("t2_count127", count, 127);
    check("t2_ovf", ovf_err, 1);
    for (int i = 0; i < DEPTH - 1; i++) cyc(1, 0, 0, 1, '0);
    cyc(1, 0, 0, 0, '0);
    check("t2_seen_n", seen.size(), 128);
    for (int i = 0; i < seen.size(); i++) check("t2_seen", seen[i], i);
    check("t2_empty", empty, 1);

    // Pointer wrap with alternating push/pop
    do_reset();
    seen.delete();
    for (int i = 0; i < 300; i++) begin
      cyc(1, 0, 1, 0, WIDTH'(16'h1000 + i));
      check("t3_count_le1", count, 1);
      cyc(1, 0, 0, 1, '0);
    end
    cyc(1, 0, 0, 0, '0);
    check("t3_seen_n", seen.size(), 300);
    for (int i = 0; i < seen.size(); i++) check("t3_seen", seen[i], 16'h1000 + i);
    check("t3_ovf", ovf_err, 0);
    check("t3_udf", udf_err, 0);

    // Push+pop at empty: no bypass
    do_reset();
    cyc(1, 0, 1, 1, 16'h00AA);
    check("t4_udf", udf_err, 1);
    check("t4_valid", valid_out, 0);
    check("t4_count", count, 1);
    cyc(1, 0, 0, 1, '0);
    check("t4_data", data_out, 16'h00AA);
    check("t4_valid2", valid_out, 1);

    // Flush keeps error flags and ignores the write
    for (int i = 1; i <= 3; i++) cyc(1, 0, 1, 0, WIDTH'(i));
    cyc(1, 1, 1, 0, 16'h0077);
    check("t5_count", count, 0);
    check("t5_empty", empty, 1);
    check("t5_valid", valid_out, 0);
    check("t5_udf_kept", udf_err, 1);
    check("t5_ovf_kept", ovf_err, 0);
    cyc(1, 0, 1, 0, 16'h0042);
    cyc(1, 0, 0, 1, '0);
    check("t5_data", data_out, 16'h0042);

    // clk_en freeze, flush while disabled, mid-fill reset
    do_reset();
    cyc(1, 0, 1, 0, 16'h0011);
    cyc(1, 0, 0, 1, '0);
    check("t6_valid_a", valid_out, 1);
    cyc(0, 0, 0, 1, '0);
    check("t6_valid_b", valid_out, 1);
    check("t6_data_b", data_out, 16'h0011);
    cyc(0, 0, 0, 0, '0);
    check("t6_valid_c", valid_out, 1);
    cyc(1, 0, 0, 0, '0);
    check("t6_valid_d", valid_out, 0);
    cyc(1, 0, 1, 0, 16'h0001);
    cyc(1, 0, 1, 0, 16'h0002);
    cyc(0, 1, 0, 0, '0);
    check("t6_flush_noen", count, 2);
    for (int i = 0; i < 8; i++) cyc(1, 0, 1, 0, WIDTH'(i));
    check("t6_count10", count, 10);
    reset = 1'b1;
    cyc(1, 0, 1, 0, 16'h0005);
    reset = 1'b0;
    check("t6_rst_count", count, 0);
    check("t6_rst_empty", empty, 1);
    cyc(1, 0, 0, 0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
